bt_pipelined_addsub: RTL and testbench
======================================

BT_PIPELINED_ADDSUB -- requirements
Module: bt_pipelined_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH mod STAGES SHALL be 0, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result stage holds valid data.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port result  output  WIDTH  sum/difference.
REQ-013 SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow.
REQ-015 SHALL have ports negative and zero  output  1 each  result[WIDTH-1] and (result == 0).

Function
REQ-016 SHALL compute a + (b XOR {WIDTH{sub}}) + sub, using slice width WIDTH/STAGES per stage, with carry registered between stages and operands/partial results registered alongside.
REQ-017 SHALL accept a transfer when in_valid && in_ready; transfer on out_valid && out_ready completes the result.
REQ-018 SHALL drive in_ready = !out_valid || out_ready; when in_ready is 0, all stages hold (global stall, bubbles not collapsed).
REQ-019 SHALL present a result exactly STAGES cycles after acceptance when out_ready stays 1; throughput one operation per cycle.
REQ-020 SHALL carry a valid bit per stage; a cycle with in_ready=1 and in_valid=0 SHALL insert a bubble.
REQ-021 SHALL hold result and flags stable while out_valid=1 and out_ready=0.
REQ-022 SHALL compute overflow = (~a_msb & ~b'_msb & r_msb) | (a_msb & b'_msb & ~r_msb), where b' is b after conditional inversion.
REQ-023 SHALL compute negative and zero from the final result as presented (post-saturation when enabled).
REQ-024 SHALL produce wrap-around modulo 2^WIDTH results when saturation is absent or off.
REQ-025 SHALL ignore a, b and sub when no transfer occurs.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all stage valid bits, carries and data registers; out_valid, result, cout, overflow, negative and zero SHALL read 0; zero SHALL read 0 while out_valid=0.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no result SHALL emerge after release.
REQ-028 SHALL drive in_ready=1 during and after reset.

Configuration
REQ-029 SHALL, with macro BT_ADDSUB_SATURATE_EN defined, add input port sat (1 bit, travels with operands); when sat=1 and overflow=1, result SHALL clamp to max positive (0111..1) if a_msb=0, else to min negative (100..0); overflow SHALL still report 1.
REQ-030 SHALL, with BT_ADDSUB_SATURATE_EN undefined, have no sat port and always wrap.

Verification (WIDTH=64, STAGES=4)
REQ-031 SHALL test add: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result=0, cout=1, zero=1, overflow=0, out_valid 4 cycles after accept.
REQ-032 SHALL test sub overflow: a=0x8000_0000_0000_0000, b=1, sub=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cout=1; with BT_ADDSUB_SATURATE_EN and sat=1 -> result=0x8000_0000_0000_0000, negative=1.
REQ-033 SHALL test back-to-back stream: 8 consecutive adds i+i (i=1..8) with out_ready=1 -> results 2,4,...,16 on 8 consecutive cycles.
REQ-034 SHALL test backpressure: out_ready=0 for 5 cycles with pipeline full -> in_ready=0, result stable, no loss or duplication after release.
REQ-035 SHALL test mid-flight reset: rst_n low for 1 cycle with 3 ops in flight -> out_valid=0 immediately, no results afterwards.
REQ-036 SHALL test bubble: valid, idle, valid (5+3, then 9-9) -> out_valid pattern 1,0,1; results 8 then 0 with zero=1, cout=1.

Source files
------------

// File: rtl/bt_pipelined_addsub.sv
// rtl/bt_pipelined_addsub.sv - pipelined carry-slice adder/subtractor with valid/ready handshake (optional saturation: BT_ADDSUB_SATURATE_EN)
module bt_pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef BT_ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  // Refuse to elaborate when the operand cannot be split into equal slices.
  generate
    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("bt_pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end
  endgenerate

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage s holds the operands plus result slices 0..s-1 and the carry into slice s.
  // Stage 0 is the operand capture register; the output register sits after stage LAST.
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] sat_q, sat_d;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  bx_d [STAGES];
  logic [WIDTH-1:0]  r_q  [STAGES];
  logic [WIDTH-1:0]  r_d  [STAGES];

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;

  logic             advance;
  logic             sat_in;
  logic [SW:0]      slice_sum;
  logic [SW:0]      fin_sum;
  logic [WIDTH-1:0] raw_res;
  logic             ovf_raw;

`ifdef BT_ADDSUB_SATURATE_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  // The whole pipe moves as one; a full output register that is not taken freezes every stage.
  assign in_ready = !ov_q || out_ready;
  assign advance  = in_ready;

  // Next state of the slice stages: capture operands, then add one slice per stage.
  always_comb begin
    v_d       = '0;
    c_d       = '0;
    sat_d     = '0;
    slice_sum = '0;
    for (int s = 0; s < STAGES; s++) begin
      a_d[s]  = '0;
      bx_d[s] = '0;
      r_d[s]  = '0;
    end

    // Bubbles carry zero data so nothing stale ever reaches the output.
    v_d[0]   = in_valid;
    c_d[0]   = in_valid & sub;
    sat_d[0] = in_valid & sat_in;
    a_d[0]   = in_valid ? a : '0;
    bx_d[0]  = in_valid ? (b ^ {WIDTH{sub}}) : '0;

    for (int s = 1; s < STAGES; s++) begin
      slice_sum = {1'b0, a_q[s-1][(s-1)*SW +: SW]}
                + {1'b0, bx_q[s-1][(s-1)*SW +: SW]}
                + {{SW{1'b0}}, c_q[s-1]};
      v_d[s]   = v_q[s-1];
      sat_d[s] = sat_q[s-1];
      a_d[s]   = a_q[s-1];
      bx_d[s]  = bx_q[s-1];
      c_d[s]   = slice_sum[SW];
      r_d[s]   = r_q[s-1];
      r_d[s][(s-1)*SW +: SW] = slice_sum[SW-1:0];
    end
  end

  // Top slice, flags and optional clamp feeding the output register.
  always_comb begin
    fin_sum = {1'b0, a_q[LAST][LAST*SW +: SW]}
            + {1'b0, bx_q[LAST][LAST*SW +: SW]}
            + {{SW{1'b0}}, c_q[LAST]};
    raw_res = r_q[LAST];
    raw_res[LAST*SW +: SW] = fin_sum[SW-1:0];

    ovf_raw = (~a_q[LAST][WIDTH-1] & ~bx_q[LAST][WIDTH-1] &  raw_res[WIDTH-1])
            | ( a_q[LAST][WIDTH-1] &  bx_q[LAST][WIDTH-1] & ~raw_res[WIDTH-1]);

    res_d = raw_res;
    if (sat_q[LAST] && ovf_raw) begin
      res_d = a_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    if (!v_q[LAST]) begin
      res_d = '0;
    end

    ov_d   = v_q[LAST];
    cout_d = v_q[LAST] & fin_sum[SW];
    ovf_d  = v_q[LAST] & ovf_raw;
    neg_d  = v_q[LAST] & res_d[WIDTH-1];
    zero_d = v_q[LAST] & (res_d == '0);
  end

  // Pipeline registers: cleared asynchronously, advanced only when the output can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      sat_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]  <= '0;
        bx_q[s] <= '0;
        r_q[s]  <= '0;
      end
      ov_q   <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      v_q    <= v_d;
      c_q    <= c_d;
      sat_q  <= sat_d;
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]  <= a_d[s];
        bx_q[s] <= bx_d[s];
        r_q[s]  <= r_d[s];
      end
      ov_q   <= ov_d;
      res_q  <= res_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bt_pipelined_addsub.sv
// tb/tb_bt_pipelined_addsub.sv - scoreboard bench for bt_pipelined_addsub
module tb_bt_pipelined_addsub;
  localparam int W = 64;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout, overflow, negative, zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   pop_log[$];

  logic         hold_pend = 1'b0;
  logic [W-1:0] hold_res;
  logic         hold_c, hold_v;

  always #5 clk = ~clk;

  bt_pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .sub(sub),
`ifdef BT_ADDSUB_SATURATE_EN
    .sat(sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .cout(cout),
    .overflow(overflow),
    .negative(negative),
    .zero(zero)
  );

  // Reference: unsigned arithmetic for result/carry, wide signed arithmetic for overflow.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic ms, input logic msat);
    exp_t e;
    logic signed [W+1:0] sa, sb, sv, maxv, minv;
    sa = $signed({ma[W-1], ma[W-1], ma});
    sb = $signed({mb[W-1], mb[W-1], mb});
    maxv = '0;
    maxv[W-2:0] = '1;
    minv = '1;
    minv[W-2:0] = '0;
    if (!ms) begin
      {e.c, e.res} = {1'b0, ma} + {1'b0, mb};
      sv = sa + sb;
    end else begin
      e.res = ma - mb;
      e.c   = (ma >= mb);
      sv    = sa - sb;
    end
    e.v = (sv > maxv) || (sv < minv);
`ifdef BT_ADDSUB_SATURATE_EN
    if (msat && e.v) e.res = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    if (msat) e.res = e.res;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // Monitor/scoreboard: compare every completed transfer, check hold stability, log accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      cyc++;
      if (hold_pend) begin
        chk("hold_valid", W'(out_valid), W'(1'b1));
        chk("hold_result", result, hold_res);
        chk("hold_flags", W'({cout, overflow}), W'({hold_c, hold_v}));
      end
      hold_pend = out_valid && !out_ready;
      hold_res  = result;
      hold_c    = cout;
      hold_v    = overflow;
      if (out_valid && out_ready) begin
        pop_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", W'(1'b1), W'(1'b0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("cout", W'(cout), W'(e.c));
          chk("overflow", W'(overflow), W'(e.v));
          chk("negative", W'(negative), W'(e.res[W-1]));
          chk("zero", W'(zero), W'(e.res == '0));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, sat));
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                      input logic ts, input logic tsat);
    int n;
    a = ta; b = tb2; sub = ts; sat = tsat; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", W'(1'b1), W'(1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    sub = 1'($urandom);
    sat = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", W'(exp_q.size()), W'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("valid_timeout", W'(out_valid), W'(1'b1));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n;
    // Reset values
    #12;
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_in_ready", W'(in_ready), W'(1'b1));
    chk("rst_result", result, '0);
    chk("rst_flags", W'({cout, overflow, negative, zero}), W'(4'b0000));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Carry through every slice, latency
    out_ready = 1'b1;
    send('1, 64'd1, 1'b0, 1'b0);
    idle();
    wait_valid(n);
    chk("latency", W'(n), W'(S));
    chk("add_result", result, '0);
    chk("add_flags", W'({cout, zero, overflow}), W'(3'b110));
    drain();

    // Subtract overflow, saturation requested
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
    idle();
    wait_valid(n);
    chk("subovf_flags", W'({overflow, cout}), W'(2'b11));
`ifdef BT_ADDSUB_SATURATE_EN
    chk("subovf_result", result, 64'h8000_0000_0000_0000);
    chk("subovf_negative", W'(negative), W'(1'b1));
`else
    chk("subovf_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("subovf_negative", W'(negative), W'(1'b0));
`endif
    drain();
    send(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    idle();
    drain();

    // Back-to-back stream
    pop_log.delete();
    for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
    idle();
    drain();
    chk("stream_count", W'(pop_log.size()), W'(8));
    if (pop_log.size() == 8) chk("stream_span", W'(pop_log[7] - pop_log[0]), W'(7));

    // Bubble: valid, idle, valid
    pop_log.delete();
    send(64'd5, 64'd3, 1'b0, 1'b0);
    idle();
    @(posedge clk); #1;
    send(64'd9, 64'd9, 1'b1, 1'b0);
    idle();
    drain();
    chk("bubble_count", W'(pop_log.size()), W'(2));
    if (pop_log.size() == 2) chk("bubble_gap", W'(pop_log[1] - pop_log[0]), W'(2));

    // Backpressure with full pipe
    pop_log.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(W'(i * 3 + 1), W'(i + 100), 1'($urandom), 1'b0);
    a = 64'd77; b = 64'd11; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", W'(in_ready), W'(1'b0));
      chk("stall_out_valid", W'(out_valid), W'(1'b1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(64'd77, 64'd11, 1'b1, 1'b0);
    idle();
    drain();
    chk("stall_count", W'(pop_log.size()), W'(6));

    // Mid-flight reset
    pop_log.delete();
    for (int i = 0; i < 3; i++) send(W'(i + 40), W'(i), 1'b0, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(1'b0));
    chk("midrst_in_ready", W'(in_ready), W'(1'b1));
    chk("midrst_zero", W'(zero), W'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_output", W'(out_valid), W'(1'b0));
    end
    chk("midrst_pops", W'(pop_log.size()), W'(0));
    @(posedge clk); #1;

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 3) != 0;
      a = pick();
      b = pick();
      sub = 1'($urandom);
      sat = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    idle();
    out_ready = 1'b1;
    drain();
    chk("final_queue_empty", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
